// File: rtl/mips_md_pkg.sv
// Shared definitions for the MIPS150 HI/LO multiply/divide unit:
// funct codes, FSM state and datapath mode encodings.
package mips_md_pkg;

    localparam int unsigned MD_WIDTH = 32;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_MUL,
        MD_DIV
    } md_state_t;

    typedef enum logic {
        MODE_MUL,
        MODE_DIV
    } md_mode_t;

endpackage

// File: rtl/md_iter_core.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide,
// one step per cycle, with the iteration counter.
module md_iter_core
    import mips_md_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned ITERS = WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  md_mode_t           mode,
    input  logic [WIDTH-1:0]   init_lo,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               last
);

    localparam int unsigned CW = $clog2(ITERS) + 1;

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [CW-1:0]      cnt;
    md_mode_t           mode_q;

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_cand;
    logic [WIDTH:0] div_diff;

    // Multiply: {HI,LO} = {partial, multiplier}, add on LSB then shift right.
    // Divide:   {HI,LO} = {remainder, dividend}, shift left then trial-subtract.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_cand = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_cand - {1'b0, opnd};
        acc_next = {mul_sum, acc[WIDTH-1:1]};
        if (mode_q == MODE_DIV) begin
            if (!div_diff[WIDTH]) begin
                acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {div_cand[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign last = (cnt == CW'(ITERS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            opnd   <= '0;
            cnt    <= '0;
            mode_q <= MODE_MUL;
        end else if (load) begin
            acc    <= {{WIDTH{1'b0}}, init_lo};
            opnd   <= operand;
            cnt    <= '0;
            mode_q <= mode;
        end else if (step) begin
            acc    <= acc_next;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit for the EX stage: FSM, sign handling,
// architectural HI/LO registers and pipeline handshake.
module mult_div_unit
    import mips_md_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned ITERS = WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             Stall,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    md_state_t state;

    logic             is_mul;
    logic             is_div;
    logic             is_signed;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             accept;

    logic             neg_main;
    logic             neg_rem;
    logic             b_zero;
    logic [WIDTH-1:0] a_raw;

    logic [2*WIDTH-1:0] acc_next;
    logic               core_last;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        is_mul    = (funct == F_MULT) || (funct == F_MULTU);
        is_div    = (funct == F_DIV)  || (funct == F_DIVU);
        is_signed = (funct == F_MULT) || (funct == F_DIV);
        sign_a    = is_signed & A[WIDTH-1];
        sign_b    = is_signed & B[WIDTH-1];
        a_mag     = sign_a ? -A : A;
        b_mag     = sign_b ? -B : B;
        accept    = Start && (state == MD_IDLE) && (is_mul || is_div);
    end

    assign Stall = Busy & Start;

    md_iter_core #(
        .WIDTH (WIDTH),
        .ITERS (ITERS)
    ) u_core (
        .clk      (Clock),
        .rst      (Reset),
        .load     (accept),
        .step     (state != MD_IDLE),
        .mode     (is_div ? MODE_DIV : MODE_MUL),
        .init_lo  (is_div ? a_mag : b_mag),
        .operand  (is_div ? b_mag : a_mag),
        .acc_next (acc_next),
        .last     (core_last)
    );

    // Sign fix-up applies to the final step's result so no extra cycle is spent.
    // Divide-by-zero: |A| remainder and all-ones quotient, then normal fix-up.
    always_comb begin
        prod    = neg_main ? -acc_next : acc_next;
        quo_fix = neg_main ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
        rem_fix = neg_rem ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
        if (b_zero) begin
            quo_fix = neg_main ? WIDTH'(1) : '1;
            rem_fix = a_raw;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= MD_IDLE;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            HI       <= '0;
            LO       <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            b_zero   <= 1'b0;
            a_raw    <= '0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                MD_IDLE: begin
                    if (Start) begin
                        if (is_mul || is_div) begin
                            neg_main <= sign_a ^ sign_b;
                            neg_rem  <= sign_a;
                            b_zero   <= (B == '0);
                            a_raw    <= A;
                            Busy     <= 1'b1;
                            if (is_div) begin
                                state <= MD_DIV;
                            end else begin
                                state <= MD_MUL;
                            end
                        end else if (funct == F_MTHI) begin
                            HI <= A;
                        end else if (funct == F_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                MD_MUL: begin
                    if (core_last) begin
                        HI    <= prod[2*WIDTH-1:WIDTH];
                        LO    <= prod[WIDTH-1:0];
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= MD_IDLE;
                    end
                end
                MD_DIV: begin
                    if (core_last) begin
                        HI    <= rem_fix;
                        LO    <= quo_fix;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= MD_IDLE;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MTLO  = 6'b010011;
    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIV   = 6'b011010;
    localparam logic [5:0] DIVU  = 6'b011011;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [5:0]  funct = 6'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Busy;
    logic        Done;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(32), .ITERS(32)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Start (Start),
        .funct (funct),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .Done  (Done),
        .Stall (Stall),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 Clock = ~Clock;

    // Issues one operation and watches 40 cycles; reports Busy/Done counts and the result seen with Done.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int busy_n, output int done_n,
                          output logic [31:0] hi_r, output logic [31:0] lo_r);
        Start = 1'b1; funct = f; A = a; B = b;
        @(posedge Clock); #1;
        Start = 1'b0; A = 32'hDEADBEEF; B = 32'h0;
        busy_n = 0; done_n = 0; hi_r = 'x; lo_r = 'x;
        for (int i = 0; i < 40; i++) begin
            if (Busy) busy_n++;
            if (Done) begin
                done_n++;
                hi_r = HI;
                lo_r = LO;
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        checks++;
        if ({Busy, Done, Stall} !== 3'b000 || HI !== 32'h0 || LO !== 32'h0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b stall=%b hi=%h lo=%h, want 0 0 0 0 0", Busy, Done, Stall, HI, LO);
        end
    endtask

    task automatic test_multu();
        int bn, dn; logic [31:0] h, l;
        run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, bn, dn, h, l);
        checks++;
        if (bn !== 32) begin errors++; $display("FAIL multu_busy: got %0d cycles want 32", bn); end
        checks++;
        if (dn !== 1) begin errors++; $display("FAIL multu_done: got %0d pulses want 1", dn); end
        checks++;
        if (h !== 32'hFFFFFFFE || l !== 32'h00000001) begin
            errors++; $display("FAIL multu_result: got %h_%h want fffffffe_00000001", h, l);
        end
    endtask

    task automatic test_mult();
        int bn, dn; logic [31:0] h, l;
        run_op(MULT, 32'hFFFFFFFE, 32'h00000003, bn, dn, h, l);
        checks++;
        if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFA) begin
            errors++; $display("FAIL mult_neg: got %h_%h want ffffffff_fffffffa", h, l);
        end
        run_op(MULT, 32'hFFFFFFF9, 32'hFFFFFFFD, bn, dn, h, l);
        checks++;
        if (h !== 32'h0 || l !== 32'd21) begin
            errors++; $display("FAIL mult_negneg: got %h_%h want 00000000_00000015", h, l);
        end
    endtask

    task automatic test_div();
        int bn, dn; logic [31:0] h, l;
        run_op(DIV, 32'hFFFFFFF9, 32'h00000002, bn, dn, h, l);
        checks++;
        if (l !== 32'hFFFFFFFD || h !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL div_signed: got lo=%h hi=%h want fffffffd ffffffff", l, h);
        end
        checks++;
        if (bn !== 32 || dn !== 1) begin
            errors++; $display("FAIL div_timing: got busy=%0d done=%0d want 32 1", bn, dn);
        end
        run_op(DIVU, 32'd100, 32'd7, bn, dn, h, l);
        checks++;
        if (l !== 32'd14 || h !== 32'd2) begin
            errors++; $display("FAIL divu: got lo=%0d hi=%0d want 14 2", l, h);
        end
    endtask

    task automatic test_div_edge();
        int bn, dn; logic [31:0] h, l;
        run_op(DIVU, 32'd5, 32'd0, bn, dn, h, l);
        checks++;
        if (h !== 32'd5 || l !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL divu_zero: got hi=%h lo=%h want 00000005 ffffffff", h, l);
        end
        run_op(DIV, 32'hFFFFFFFB, 32'd0, bn, dn, h, l);
        checks++;
        if (h !== 32'hFFFFFFFB || l !== 32'h00000001) begin
            errors++; $display("FAIL div_zero_neg: got hi=%h lo=%h want fffffffb 00000001", h, l);
        end
        run_op(DIV, 32'h80000000, 32'hFFFFFFFF, bn, dn, h, l);
        checks++;
        if (l !== 32'h80000000 || h !== 32'h0) begin
            errors++; $display("FAIL div_overflow: got lo=%h hi=%h want 80000000 00000000", l, h);
        end
    endtask

    task automatic test_stall_mtx();
        int  stalls = 0;
        bit  hi_bad = 0;
        Start = 1'b1; funct = MTHI; A = 32'h0000AAAA;
        @(posedge Clock); #1;
        funct = MTLO; A = 32'h00005555;
        @(posedge Clock); #1;
        Start = 1'b0;
        checks++;
        if (HI !== 32'h0000AAAA || LO !== 32'h00005555 || Busy !== 1'b0 || Done !== 1'b0) begin
            errors++; $display("FAIL mthi_mtlo_idle: got hi=%h lo=%h busy=%b done=%b want 0000aaaa 00005555 0 0", HI, LO, Busy, Done);
        end
        Start = 1'b1; funct = MULTU; A = 32'd2; B = 32'd3;
        @(posedge Clock); #1;
        funct = MTHI; A = 32'h00001234;
        for (int i = 0; i < 40; i++) begin
            if (Done) break;
            if (Stall) stalls++;
            if (HI !== 32'h0000AAAA) hi_bad = 1;
            @(posedge Clock); #1;
        end
        checks++;
        if (stalls !== 32 || hi_bad) begin
            errors++; $display("FAIL stall_busy: got stalls=%0d hi_changed=%0d want 32 0", stalls, hi_bad);
        end
        checks++;
        if (Done !== 1'b1 || Stall !== 1'b0 || HI !== 32'h0 || LO !== 32'd6) begin
            errors++; $display("FAIL done_cycle: got done=%b stall=%b hi=%h lo=%h want 1 0 00000000 00000006", Done, Stall, HI, LO);
        end
        @(posedge Clock); #1;
        Start = 1'b0;
        checks++;
        if (HI !== 32'h00001234 || LO !== 32'd6 || Busy !== 1'b0 || Done !== 1'b0) begin
            errors++; $display("FAIL mthi_replay: got hi=%h lo=%h busy=%b done=%b want 00001234 00000006 0 0", HI, LO, Busy, Done);
        end
    endtask

    task automatic test_reset_mid();
        int bn, dn; logic [31:0] h, l;
        int late_done = 0;
        Start = 1'b1; funct = MULTU; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (9) @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            errors++; $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", Busy, Done, HI, LO);
        end
        for (int i = 0; i < 40; i++) begin
            if (Done || Busy) late_done++;
            @(posedge Clock); #1;
        end
        checks++;
        if (late_done !== 0) begin
            errors++; $display("FAIL reset_abort: got %0d busy/done cycles after reset want 0", late_done);
        end
        run_op(MULTU, 32'd3, 32'd4, bn, dn, h, l);
        checks++;
        if (l !== 32'd12 || h !== 32'd0 || dn !== 1) begin
            errors++; $display("FAIL after_reset_mul: got lo=%0d hi=%0d done=%0d want 12 0 1", l, h, dn);
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_edge();
        test_stall_mtx();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
